alu_frame_sequencer: RTL and testbench
======================================

# alu_frame_sequencer

Controller that sequences the serial `mtm_Alu`. It accepts one operation (A, B, op) on a valid/ready request port and serializes it onto the ALU's `sin` line as nine 11-bit packets, including the input CRC. It then deserializes the ALU's `sout` response frame and returns result, flags and error status on a valid/ready response port. It sits between any parallel requester (tester, scoreboard-driven stimulus, system master) and the ALU's serial pins, and owns the ALU exclusively: one operation in flight at a time.

## Interface
- `TIMEOUT_CYCLES`, 1000: consecutive idle `sout` samples (line at 1) tolerated while waiting for a start bit before the operation is aborted.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_a`  in  32  operand A.
- `req_b`  in  32  operand B.
- `req_op`  in  3  opcode, passed through unchecked (AND 000, OR 001, ADD 100, SUB 101; others reach the ALU as-is).
- `req_crc_inv`  in  1  when 1, the transmitted CRC is bitwise inverted (error injection).
- `alu_sin`  out  1  to ALU `sin`; idles at 1.
- `alu_sout`  in  1  from ALU `sout`; synchronous to `clk`.
- `rsp_valid`  out  1  response present; held until `rsp_ready`.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_result`  out  32  result word (data frames only).
- `rsp_flags`  out  4  ALU flag nibble from the control packet.
- `rsp_crc`  out  3  raw CRC3 from the control packet; not checked.
- `rsp_err`  out  1  ALU returned an error frame.
- `rsp_err_flags`  out  6  error flag bits from the error packet.
- `rsp_timeout`  out  1  no start bit within `TIMEOUT_CYCLES`.

## Operation
- Packet format (11 bits, sent MSB first): start 0, type (0 data / 1 cmd), 8 payload bits MSB first, stop 1.
- TX frame: `req_b[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`, then `req_a` in the same byte order (all data packets), then a cmd packet with payload {0, op[2:0], crc[3:0]}. Total 99 bits, no gaps.
- CRC4: polynomial x^4+x+1, initial value 0, computed MSB first over the 68-bit vector {B, A, 1'b1, op}. The block may compute it serially while shifting, or combinationally at accept. XOR with 4'hF when `req_crc_inv` is set (value latched at accept).
- FSM: IDLE -> SEND (on `req_valid && req_ready`; latch all req fields) -> WAIT_RSP (after bit 99) -> RECV -> DONE -> IDLE (on `rsp_ready`).
- RX: in WAIT_RSP or between packets in RECV, a sample of `alu_sout`=0 is a start bit; the next 10 samples complete the packet.
  - First packet type=1: error frame. Payload is {1, err_flags[5:0], parity}. Set `rsp_err`, load `rsp_err_flags`, go to DONE.
  - Otherwise, four data packets fill `rsp_result` MSB byte first. A fifth (cmd) packet with payload {0, flags[3:0], crc[2:0]} loads `rsp_flags`/`rsp_crc`, then go to DONE.
- Timeout counter: cleared on every start bit and on entry to WAIT_RSP; increments on each idle sample. On reaching `TIMEOUT_CYCLES`, set `rsp_timeout` and go to DONE; partial `rsp_result` is undefined.
- Stop bits are not checked. `rsp_*` fields are cleared at accept of each new request.

## Timing
- Reset values: `alu_sin`=1, `req_ready`=1, `rsp_valid`=0, all `rsp_*`=0, FSM=IDLE.
- Accept at edge E0. TX bit k (k=0..98) is driven on `alu_sin` from edge E(k+1) to E(k+2). `alu_sin` returns to 1 at E100, and the block enters WAIT_RSP at E100.
- `rsp_valid` rises on the edge after the final stop bit (error packet or 5th packet) is sampled, or the edge after the timeout count is reached.
- Response handshake completes on an edge with `rsp_valid && rsp_ready`. `req_ready` rises on that same edge. Back-to-back: next accept is possible one edge later.
- `req_valid` while busy is ignored (not latched). A `rsp_ready` held high early has no effect until `rsp_valid`.
- `rst` mid-operation (any state): immediate return to reset values; the in-flight operation is lost. The ALU must be reset separately by the system.

## Test plan
- A=0, B=0, op=AND, no inversion -> cmd payload 0x0B (crc 4'b1011). Bits 88..98 of the TX stream are 0,1,0000,1011,1. Data packet payloads are all 0x00.
- A=10, B=20, op=ADD against the ALU -> `rsp_result`=30, `rsp_err`=0, `rsp_timeout`=0. `rsp_valid` holds until `rsp_ready` is asserted 5 cycles late.
- Same request with `req_crc_inv`=1 -> ALU error frame; `rsp_err`=1 and `rsp_err_flags` shows the CRC-error bit.
- `TIMEOUT_CYCLES`=50, `alu_sout` tied to 1 -> `rsp_timeout`=1 exactly 50 idle samples after E100.
- Assert `rst` at TX bit 40 -> `alu_sin`=1 and `req_ready`=1 immediately. A fresh request then completes normally.
- Two back-to-back requests with `req_valid` held high throughout -> second accepted one edge after the first response handshake; `req_valid` during busy is never double-accepted.

Source files
------------

// File: rtl/alu_frame_sequencer.sv
// alu_frame_sequencer
//    Owns a serial mtm_Alu. Takes one (A, B, op) request on a valid/ready
//    port, shifts it out on alu_sin as nine 11-bit packets (8 data + cmd
//    with CRC4), then collects the response frame from alu_sout and presents
//    it on a valid/ready response port. One operation in flight at a time.
//
// Ports
//    clk, rst          clock, async active-high reset
//    req_valid/ready   request handshake (ready only in IDLE)
//    req_a, req_b      32-bit operands
//    req_op            3-bit opcode, passed through unchecked
//    req_crc_inv       invert transmitted CRC (error injection)
//    alu_sin           serial line to ALU, idles high
//    alu_sout          serial line from ALU
//    rsp_valid/ready   response handshake, valid held until ready
//    rsp_result        32-bit result (data frames)
//    rsp_flags         ALU flag nibble
//    rsp_crc           raw CRC3 from ALU control packet
//    rsp_err           ALU returned an error frame
//    rsp_err_flags     error flag bits from the error packet
//    rsp_timeout       no start bit within TIMEOUT_CYCLES idle samples
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | req_ready high, waiting for a request
// S_SEND     | shifting the 99-bit request frame onto alu_sin
// S_WAIT_RSP | waiting for the first start bit of the response
// S_RECV     | receiving response packets / waiting between packets
// S_DONE     | response presented, waiting for rsp_ready

module alu_frame_sequencer #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [2:0]  req_op,
   input  logic        req_crc_inv,
   output logic        alu_sin,
   input  logic        alu_sout,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [3:0]  rsp_flags,
   output logic [2:0]  rsp_crc,
   output logic        rsp_err,
   output logic [5:0]  rsp_err_flags,
   output logic        rsp_timeout
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_RSP,
      S_RECV,
      S_DONE
   } state_t;

   state_t        state;
   logic [98:0]   tx_shift;
   logic [6:0]    tx_cnt;
   logic [8:0]    rx_shift;
   logic [3:0]    rx_cnt;
   logic          rx_busy;
   logic [2:0]    pkt_idx;
   logic [TW-1:0] tmo_cnt;
   logic [98:0]   tx_frame;

   // x^4+x+1, init 0, MSB first
   function automatic logic [3:0] crc4(input logic [67:0] d);
      logic [3:0] c;
      logic       fb;
      c = 4'h0;
      for (int i = 67; i >= 0; i--) begin
         fb = c[3] ^ d[i];
         c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
      end
      return c;
   endfunction

   function automatic logic [10:0] data_pkt(input logic [7:0] byte_in);
      return {1'b0, 1'b0, byte_in, 1'b1};
   endfunction

   always_comb begin
      logic [3:0] crc;
      crc = crc4({req_b, req_a, 1'b1, req_op}) ^ {4{req_crc_inv}};
      tx_frame = {data_pkt(req_b[31:24]), data_pkt(req_b[23:16]),
                  data_pkt(req_b[15:8]),  data_pkt(req_b[7:0]),
                  data_pkt(req_a[31:24]), data_pkt(req_a[23:16]),
                  data_pkt(req_a[15:8]),  data_pkt(req_a[7:0]),
                  {1'b0, 1'b1, 1'b0, req_op, crc, 1'b1}};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         req_ready     <= 1'b1;
         alu_sin       <= 1'b1;
         tx_shift      <= '1;
         tx_cnt        <= '0;
         rx_shift      <= '0;
         rx_cnt        <= '0;
         rx_busy       <= 1'b0;
         pkt_idx       <= '0;
         tmo_cnt       <= TMO_LOAD;
         rsp_valid     <= 1'b0;
         rsp_result    <= '0;
         rsp_flags     <= '0;
         rsp_crc       <= '0;
         rsp_err       <= 1'b0;
         rsp_err_flags <= '0;
         rsp_timeout   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  tx_shift      <= tx_frame;
                  tx_cnt        <= '0;
                  req_ready     <= 1'b0;
                  rsp_result    <= '0;
                  rsp_flags     <= '0;
                  rsp_crc       <= '0;
                  rsp_err       <= 1'b0;
                  rsp_err_flags <= '0;
                  rsp_timeout   <= 1'b0;
                  state         <= S_SEND;
               end
            end

            S_SEND: begin
               alu_sin  <= tx_shift[98];
               tx_shift <= {tx_shift[97:0], 1'b1};
               tx_cnt   <= tx_cnt + 7'd1;
               if (tx_cnt == 7'd99) begin
                  alu_sin <= 1'b1;
                  tmo_cnt <= TMO_LOAD;
                  rx_busy <= 1'b0;
                  pkt_idx <= '0;
                  state   <= S_WAIT_RSP;
               end
            end

            S_WAIT_RSP, S_RECV: begin
               if (rx_busy) begin
                  rx_shift <= {rx_shift[7:0], alu_sout};
                  rx_cnt   <= rx_cnt + 4'd1;
                  // 10th sample is the stop bit; rx_shift holds type + payload
                  if (rx_cnt == 4'd9) begin
                     rx_busy <= 1'b0;
                     if (pkt_idx == 3'd0 && rx_shift[8]) begin
                        rsp_err       <= 1'b1;
                        rsp_err_flags <= rx_shift[6:1];
                        state         <= S_DONE;
                     end else if (pkt_idx == 3'd4) begin
                        rsp_flags <= rx_shift[6:3];
                        rsp_crc   <= rx_shift[2:0];
                        state     <= S_DONE;
                     end else begin
                        rsp_result <= {rsp_result[23:0], rx_shift[7:0]};
                        pkt_idx    <= pkt_idx + 3'd1;
                     end
                  end
               end else if (!alu_sout) begin
                  rx_busy <= 1'b1;
                  rx_cnt  <= '0;
                  tmo_cnt <= TMO_LOAD;
                  state   <= S_RECV;
               end else if (tmo_cnt == TW'(1)) begin
                  // this idle sample is the TIMEOUT_CYCLES-th in a row
                  rsp_timeout <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt - TW'(1);
               end
            end

            S_DONE: begin
               if (!rsp_valid) begin
                  rsp_valid <= 1'b1;
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_frame_sequencer.sv
module tb_alu_frame_sequencer;

   localparam int TMO = 50;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [2:0]  req_op;
   logic        req_crc_inv;
   logic        alu_sin;
   logic        alu_sout;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic [2:0]  rsp_crc;
   logic        rsp_err;
   logic [5:0]  rsp_err_flags;
   logic        rsp_timeout;

   int checks   = 0;
   int failures = 0;

   logic [98:0] f;

   alu_frame_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_crc_inv(req_crc_inv),
      .alu_sin(alu_sin), .alu_sout(alu_sout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_crc(rsp_crc),
      .rsp_err(rsp_err), .rsp_err_flags(rsp_err_flags), .rsp_timeout(rsp_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // remainder of {d, 0000} divided by 10011
   function automatic logic [3:0] crc_ref(input logic [67:0] d);
      logic [71:0] r;
      r = {d, 4'b0000};
      for (int i = 71; i >= 4; i--)
         if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
      return r[3:0];
   endfunction

   function automatic logic [98:0] build_frame(input logic [31:0] a, input logic [31:0] b,
                                                input logic [2:0] op, input logic inv);
      logic [98:0] fr;
      logic [63:0] ba;
      ba = {b, a};
      for (int i = 0; i < 8; i++)
         fr[98 - 11*i -: 11] = {2'b00, ba[63 - 8*i -: 8], 1'b1};
      fr[10:0] = {2'b01, 1'b0, op, crc_ref({b, a, 1'b1, op}) ^ {4{inv}}, 1'b1};
      return fr;
   endfunction

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic inv, input logic hold);
      req_a = a; req_b = b; req_op = op; req_crc_inv = inv;
      req_valid = 1'b1;
      tick();
      chk("accept_ready_low", req_ready, 1'b0);
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic capture(output logic [98:0] fr);
      for (int k = 0; k < 99; k++) begin
         tick();
         fr[98 - k] = alu_sin;
      end
   endtask

   task automatic send_pkt(input logic typ, input logic [7:0] pay);
      logic [10:0] p;
      p = {1'b0, typ, pay, 1'b1};
      for (int i = 10; i >= 0; i--) begin
         alu_sout = p[i];
         tick();
      end
      alu_sout = 1'b1;
   endtask

   // ALU model: decode captured frame, reply with data or CRC-error frame
   task automatic respond(input logic [98:0] fr, input logic [3:0] flags, input logic [2:0] c3);
      logic [63:0] ba;
      logic [7:0]  cmd;
      logic [31:0] a, b, res;
      logic [5:0]  ef;
      for (int i = 0; i < 8; i++) ba[63 - 8*i -: 8] = fr[96 - 11*i -: 8];
      cmd = fr[8:1];
      b = ba[63:32];
      a = ba[31:0];
      repeat (3) tick();
      if (cmd[3:0] != crc_ref({b, a, 1'b1, cmd[6:4]})) begin
         ef = 6'b010010;
         send_pkt(1'b1, {1'b1, ef, ^{1'b1, ef}});
      end else begin
         case (cmd[6:4])
            3'b000:  res = b & a;
            3'b001:  res = b | a;
            3'b100:  res = b + a;
            3'b101:  res = b - a;
            default: res = 32'h0;
         endcase
         for (int i = 3; i >= 0; i--) send_pkt(1'b0, res[8*i +: 8]);
         send_pkt(1'b1, {1'b0, flags, c3});
      end
   endtask

   task automatic valid_rise();
      chk("valid_not_early", rsp_valid, 1'b0);
      tick();
      chk("valid_rise", rsp_valid, 1'b1);
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("hs_valid_low", rsp_valid, 1'b0);
      chk("hs_req_ready", req_ready, 1'b1);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
      req_crc_inv = 1'b0; alu_sout = 1'b1; rsp_ready = 1'b0;
      repeat (2) tick();
      chk("rst_alu_sin", alu_sin, 1'b1);
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_fields", {rsp_result, rsp_flags, rsp_crc, rsp_err, rsp_err_flags, rsp_timeout}, '0);
      rst = 1'b0;
      tick();

      // all-zero AND: cmd packet 0,1,0000,1011,1
      issue(32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
      capture(f);
      chk("t1_cmd_pkt", f[10:0], 11'b01000010111);
      chk("t1_data_pkts", f[98:11], {8{11'b00000000001}});
      tick();
      chk("t1_sin_idle", alu_sin, 1'b1);
      respond(f, 4'b0010, 3'b011);
      valid_rise();
      chk("t1_result", rsp_result, 32'h0);
      chk("t1_flags", rsp_flags, 4'b0010);
      chk("t1_crc", rsp_crc, 3'b011);
      handshake();

      // 20 + 10, late rsp_ready
      issue(32'd10, 32'd20, 3'b100, 1'b0, 1'b0);
      capture(f);
      chk("t2_frame", f, build_frame(32'd10, 32'd20, 3'b100, 1'b0));
      tick();
      respond(f, 4'b0000, 3'b110);
      valid_rise();
      repeat (5) tick();
      chk("t2_valid_held", rsp_valid, 1'b1);
      chk("t2_result", rsp_result, 32'd30);
      chk("t2_err", rsp_err, 1'b0);
      chk("t2_timeout", rsp_timeout, 1'b0);
      chk("t2_crc", rsp_crc, 3'b110);
      handshake();

      // inverted CRC -> error frame
      issue(32'd10, 32'd20, 3'b100, 1'b1, 1'b0);
      capture(f);
      chk("t3_frame", f, build_frame(32'd10, 32'd20, 3'b100, 1'b1));
      tick();
      respond(f, 4'b0000, 3'b000);
      valid_rise();
      chk("t3_err", rsp_err, 1'b1);
      chk("t3_err_flags", rsp_err_flags, 6'b010010);
      chk("t3_result_cleared", rsp_result, 32'h0);
      chk("t3_timeout", rsp_timeout, 1'b0);
      handshake();

      // timeout: sout held idle
      issue(32'd1, 32'd2, 3'b100, 1'b0, 1'b0);
      capture(f);
      tick();
      repeat (49) tick();
      chk("t4_no_timeout_49", rsp_timeout, 1'b0);
      tick();
      chk("t4_timeout_50", rsp_timeout, 1'b1);
      valid_rise();
      chk("t4_err_cleared", rsp_err, 1'b0);
      handshake();

      // reset during TX bit 40
      issue(32'h12345678, 32'h0, 3'b100, 1'b0, 1'b0);
      repeat (41) tick();
      chk("t5_bit40", alu_sin, 1'b0);
      rst = 1'b1;
      #1;
      chk("t5_rst_sin", alu_sin, 1'b1);
      chk("t5_rst_ready", req_ready, 1'b1);
      chk("t5_rst_valid", rsp_valid, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      issue(32'h0F0F0000, 32'h000000F0, 3'b001, 1'b0, 1'b0);
      capture(f);
      chk("t5_frame", f, build_frame(32'h0F0F0000, 32'h000000F0, 3'b001, 1'b0));
      tick();
      respond(f, 4'b0000, 3'b001);
      valid_rise();
      chk("t5_result", rsp_result, 32'h0F0F00F0);
      handshake();

      // back-to-back with req_valid and rsp_ready held high
      rsp_ready = 1'b1;
      issue(32'hFFFF0000, 32'h0F0F0F0F, 3'b000, 1'b0, 1'b1);
      req_a = 32'h7FFFFFFF; req_b = 32'h00000001; req_op = 3'b100;
      capture(f);
      chk("t6_frame1", f, build_frame(32'hFFFF0000, 32'h0F0F0F0F, 3'b000, 1'b0));
      tick();
      respond(f, 4'b0000, 3'b010);
      valid_rise();
      chk("t6_result1", rsp_result, 32'h0F0F0000);
      tick();
      chk("t6_hs1_valid", rsp_valid, 1'b0);
      chk("t6_hs1_ready", req_ready, 1'b1);
      tick();
      chk("t6_accept2", req_ready, 1'b0);
      capture(f);
      chk("t6_frame2", f, build_frame(32'h7FFFFFFF, 32'h00000001, 3'b100, 1'b0));
      req_valid = 1'b0;
      tick();
      respond(f, 4'b0101, 3'b100);
      valid_rise();
      chk("t6_result2", rsp_result, 32'h80000000);
      chk("t6_flags2", rsp_flags, 4'b0101);
      tick();
      chk("t6_hs2_ready", req_ready, 1'b1);
      tick();
      chk("t6_no_extra_accept", req_ready, 1'b1);
      rsp_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
